// File: rtl/flexbex_ibex_pkg.sv
// Shared core types: CSR operation encoding and the CSR-port arbiter state machine.
// Also holds the address prefix that marks the read-only CSR space.
package flexbex_ibex_pkg;

    typedef enum logic [1:0] {
        CSR_READ  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_PEND = 2'd1,
        ARB_RESP = 2'd2
    } csr_arb_state_e;

    // CSR addresses with [11:10] == 2'b11 are architecturally read-only.
    localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

    function automatic logic csr_ext_illegal(
        input logic [1:0]  op,
        input logic [11:0] addr,
        input logic        allow_write
    );
        return (csr_op_e'(op) != CSR_READ) &&
               (!allow_write || (addr[11:10] == CSR_RO_PREFIX));
    endfunction

endpackage

// File: rtl/flexbex_ibex_csr_arbiter.sv
// Shares the CSR file port between the ID-stage CSR path and an external debug/config port.
// The core wins by default; a starvation counter forces a waiting ext access through.
module flexbex_ibex_csr_arbiter
    import flexbex_ibex_pkg::*;
#(
    parameter int unsigned MAX_WAIT        = 8,
    parameter bit          ALLOW_EXT_WRITE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        core_csr_access_i,
    input  logic [11:0] core_csr_addr_i,
    input  logic [31:0] core_csr_wdata_i,
    input  logic [1:0]  core_csr_op_i,
    output logic [31:0] core_csr_rdata_o,
    output logic        core_stall_o,

    input  logic        ext_req_i,
    input  logic [11:0] ext_addr_i,
    input  logic [31:0] ext_wdata_i,
    input  logic [1:0]  ext_op_i,
    output logic        ext_gnt_o,
    output logic        ext_rvalid_o,
    output logic [31:0] ext_rdata_o,
    output logic        ext_err_o,

    input  logic        trap_busy_i,

    output logic        csr_access_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_wdata_o,
    output logic [1:0]  csr_op_o,
    input  logic [31:0] csr_rdata_i
);

    localparam int unsigned     CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    csr_arb_state_e   state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [11:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [1:0]       op_q, op_d;
    logic             illegal_q, illegal_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             ext_issue;

    // A trap save/mret/dret update always wins, even over a saturated counter.
    assign ext_issue = (state_q == ARB_PEND) && !illegal_q && !trap_busy_i &&
                       (!core_csr_access_i || (wait_cnt_q == WAIT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_q       <= '0;
            illegal_q  <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            illegal_q  <= illegal_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        illegal_d  = illegal_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        case (state_q)
            ARB_IDLE: begin
                wait_cnt_d = '0;
                if (ext_req_i) begin
                    addr_d    = ext_addr_i;
                    wdata_d   = ext_wdata_i;
                    op_d      = ext_op_i;
                    illegal_d = csr_ext_illegal(ext_op_i, ext_addr_i, ALLOW_EXT_WRITE);
                    state_d   = ARB_PEND;
                end
            end
            ARB_PEND: begin
                if (illegal_q) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ARB_RESP;
                end else if (ext_issue) begin
                    rdata_d = csr_rdata_i;
                    err_d   = 1'b0;
                    state_d = ARB_RESP;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ARB_RESP: begin
                wait_cnt_d = '0;
                state_d    = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        ext_gnt_o        = (state_q == ARB_IDLE) && ext_req_i;
        ext_rvalid_o     = (state_q == ARB_RESP);
        ext_err_o        = (state_q == ARB_RESP) && err_q;
        ext_rdata_o      = rdata_q;
        core_stall_o     = ext_issue && core_csr_access_i;
        core_csr_rdata_o = csr_rdata_i;

        csr_access_o = core_csr_access_i;
        csr_addr_o   = core_csr_addr_i;
        csr_wdata_o  = core_csr_wdata_i;
        csr_op_o     = core_csr_op_i;
        if (ext_issue) begin
            csr_access_o = 1'b1;
            csr_addr_o   = addr_q;
            csr_wdata_o  = wdata_q;
            csr_op_o     = op_q;
        end
    end

endmodule

// File: tb/tb_flexbex_ibex_csr_arbiter.sv
// Self-checking bench: two arbiters (ext writes allowed / read-only) share stimulus;
// expected ext responses are queued at grant time and checked when rvalid appears.
module tb_flexbex_ibex_csr_arbiter;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk;
    logic        rst_n;
    logic        core_access;
    logic [11:0] core_addr;
    logic [31:0] core_wdata;
    logic [1:0]  core_op;
    logic        ext_req;
    logic [11:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [1:0]  ext_op;
    logic        trap_busy;

    logic [31:0] a_core_rdata, b_core_rdata;
    logic        a_stall, b_stall;
    logic        a_gnt, b_gnt;
    logic        a_rvalid, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        a_err, b_err;
    logic        a_csr_access, b_csr_access;
    logic [11:0] a_csr_addr, b_csr_addr;
    logic [31:0] a_csr_wdata, b_csr_wdata;
    logic [1:0]  a_csr_op, b_csr_op;
    logic [31:0] a_csr_rdata, b_csr_rdata;

    resp_t exp_a[$];
    resp_t exp_b[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // CSR file model: one known register, every other address reads back a tagged pattern.
    function automatic logic [31:0] csr_model(input logic [11:0] addr);
        if (addr == 12'h341) return 32'h0000_1234;
        return {20'hABCDE, addr};
    endfunction

    assign a_csr_rdata = csr_model(a_csr_addr);
    assign b_csr_rdata = csr_model(b_csr_addr);

    flexbex_ibex_csr_arbiter #(.MAX_WAIT(8), .ALLOW_EXT_WRITE(1'b1)) u_dut_a (
        .clk               (clk),
        .rst_n             (rst_n),
        .core_csr_access_i (core_access),
        .core_csr_addr_i   (core_addr),
        .core_csr_wdata_i  (core_wdata),
        .core_csr_op_i     (core_op),
        .core_csr_rdata_o  (a_core_rdata),
        .core_stall_o      (a_stall),
        .ext_req_i         (ext_req),
        .ext_addr_i        (ext_addr),
        .ext_wdata_i       (ext_wdata),
        .ext_op_i          (ext_op),
        .ext_gnt_o         (a_gnt),
        .ext_rvalid_o      (a_rvalid),
        .ext_rdata_o       (a_rdata),
        .ext_err_o         (a_err),
        .trap_busy_i       (trap_busy),
        .csr_access_o      (a_csr_access),
        .csr_addr_o        (a_csr_addr),
        .csr_wdata_o       (a_csr_wdata),
        .csr_op_o          (a_csr_op),
        .csr_rdata_i       (a_csr_rdata)
    );

    flexbex_ibex_csr_arbiter #(.MAX_WAIT(8), .ALLOW_EXT_WRITE(1'b0)) u_dut_b (
        .clk               (clk),
        .rst_n             (rst_n),
        .core_csr_access_i (core_access),
        .core_csr_addr_i   (core_addr),
        .core_csr_wdata_i  (core_wdata),
        .core_csr_op_i     (core_op),
        .core_csr_rdata_o  (b_core_rdata),
        .core_stall_o      (b_stall),
        .ext_req_i         (ext_req),
        .ext_addr_i        (ext_addr),
        .ext_wdata_i       (ext_wdata),
        .ext_op_i          (ext_op),
        .ext_gnt_o         (b_gnt),
        .ext_rvalid_o      (b_rvalid),
        .ext_rdata_o       (b_rdata),
        .ext_err_o         (b_err),
        .trap_busy_i       (trap_busy),
        .csr_access_o      (b_csr_access),
        .csr_addr_o        (b_csr_addr),
        .csr_wdata_o       (b_csr_wdata),
        .csr_op_o          (b_csr_op),
        .csr_rdata_i       (b_csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push_a(input logic [31:0] rdata, input logic err);
        resp_t r;
        r.rdata = rdata;
        r.err   = err;
        exp_a.push_back(r);
    endtask

    task automatic push_b(input logic [31:0] rdata, input logic err);
        resp_t r;
        r.rdata = rdata;
        r.err   = err;
        exp_b.push_back(r);
    endtask

    task automatic drive_ext(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wdata);
        ext_req   = 1'b1;
        ext_addr  = addr;
        ext_op    = op;
        ext_wdata = wdata;
    endtask

    // Response monitors: one line per completed ext transaction.
    always @(negedge clk) begin
        resp_t ea;
        resp_t eb;
        if (rst_n && a_rvalid) begin
            $display("A resp: rdata=0x%08h err=%0b", a_rdata, a_err);
            if (exp_a.size() == 0) begin
                chk("a_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                ea = exp_a.pop_front();
                chk("a_rdata", a_rdata, ea.rdata);
                chk("a_err", {31'd0, a_err}, {31'd0, ea.err});
            end
        end
        if (rst_n && b_rvalid) begin
            $display("B resp: rdata=0x%08h err=%0b", b_rdata, b_err);
            if (exp_b.size() == 0) begin
                chk("b_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                eb = exp_b.pop_front();
                chk("b_rdata", b_rdata, eb.rdata);
                chk("b_err", {31'd0, b_err}, {31'd0, eb.err});
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        core_access = 1'b0;
        core_addr   = '0;
        core_wdata  = '0;
        core_op     = '0;
        ext_req     = 1'b0;
        ext_addr    = '0;
        ext_wdata   = '0;
        ext_op      = '0;
        trap_busy   = 1'b0;

        sample();
        chk("rst_gnt", {31'd0, a_gnt}, 32'd0);
        chk("rst_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rst_err", {31'd0, a_err}, 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        chk("rst_stall", {31'd0, a_stall}, 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // Uncontended ext read: grant T0, issue T1, rvalid T2.
        next_cycle();
        drive_ext(12'h341, 2'd0, 32'd0);
        push_a(32'h0000_1234, 1'b0);
        push_b(32'h0000_1234, 1'b0);
        sample();
        chk("t1_gnt", {31'd0, a_gnt}, 32'd1);
        chk("t1_stall_t0", {31'd0, a_stall}, 32'd0);
        next_cycle();
        ext_req = 1'b0;
        sample();
        chk("t1_access", {31'd0, a_csr_access}, 32'd1);
        chk("t1_addr", {20'd0, a_csr_addr}, 32'h341);
        chk("t1_op", {30'd0, a_csr_op}, 32'd0);
        chk("t1_core_rdata", a_core_rdata, 32'h0000_1234);
        chk("t1_stall_t1", {31'd0, a_stall}, 32'd0);
        chk("t1_gnt_pend", {31'd0, a_gnt}, 32'd0);
        next_cycle();
        sample();
        chk("t1_rvalid", {31'd0, a_rvalid}, 32'd1);
        chk("t1_stall_t2", {31'd0, a_stall}, 32'd0);
        next_cycle();
        sample();
        chk("t1_rvalid_once", {31'd0, a_rvalid}, 32'd0);

        // Core busy every cycle: ext write forced 9 cycles after grant.
        next_cycle();
        core_access = 1'b1;
        core_addr   = 12'h305;
        core_op     = 2'd1;
        core_wdata  = 32'h1111_1111;
        drive_ext(12'h7B2, 2'd1, 32'hDEAD_BEEF);
        push_a(csr_model(12'h7B2), 1'b0);
        push_b(32'd0, 1'b1);
        sample();
        chk("t2_gnt", {31'd0, a_gnt}, 32'd1);
        for (int k = 1; k <= 9; k++) begin
            next_cycle();
            ext_req = 1'b0;
            sample();
            if (k < 9) begin
                chk("t2_wait_stall", {31'd0, a_stall}, 32'd0);
                chk("t2_wait_addr", {20'd0, a_csr_addr}, 32'h305);
                chk("t2_wait_wdata", a_csr_wdata, 32'h1111_1111);
            end else begin
                chk("t2_force_stall", {31'd0, a_stall}, 32'd1);
                chk("t2_force_access", {31'd0, a_csr_access}, 32'd1);
                chk("t2_force_addr", {20'd0, a_csr_addr}, 32'h7B2);
                chk("t2_force_op", {30'd0, a_csr_op}, 32'd1);
                chk("t2_force_wdata", a_csr_wdata, 32'hDEAD_BEEF);
                chk("t2_force_rvalid", {31'd0, a_rvalid}, 32'd0);
            end
        end
        next_cycle();
        sample();
        chk("t2_rvalid", {31'd0, a_rvalid}, 32'd1);
        chk("t2_stall_after", {31'd0, a_stall}, 32'd0);

        // Trap update blocks issue even with a saturated counter.
        next_cycle();
        trap_busy = 1'b1;
        drive_ext(12'h300, 2'd0, 32'd0);
        push_a(csr_model(12'h300), 1'b0);
        push_b(csr_model(12'h300), 1'b0);
        sample();
        chk("t3_gnt", {31'd0, a_gnt}, 32'd1);
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            ext_req = 1'b0;
            sample();
            chk("t3_trap_stall", {31'd0, a_stall}, 32'd0);
            chk("t3_trap_addr", {20'd0, a_csr_addr}, 32'h305);
            chk("t3_trap_rvalid", {31'd0, a_rvalid}, 32'd0);
        end
        next_cycle();
        trap_busy = 1'b0;
        sample();
        chk("t3_issue_stall", {31'd0, a_stall}, 32'd1);
        chk("t3_issue_addr", {20'd0, a_csr_addr}, 32'h300);
        chk("t3_issue_b_stall", {31'd0, b_stall}, 32'd1);
        next_cycle();
        core_access = 1'b0;
        core_addr   = '0;
        core_op     = '0;
        core_wdata  = '0;
        sample();
        chk("t3_rvalid", {31'd0, a_rvalid}, 32'd1);

        // Ext write into read-only space is rejected.
        next_cycle();
        drive_ext(12'hF14, 2'd1, 32'h5555_5555);
        push_a(32'd0, 1'b1);
        push_b(32'd0, 1'b1);
        sample();
        chk("t4_gnt", {31'd0, a_gnt}, 32'd1);
        next_cycle();
        ext_req = 1'b0;
        sample();
        chk("t4_a_no_access", {31'd0, a_csr_access}, 32'd0);
        chk("t4_b_no_access", {31'd0, b_csr_access}, 32'd0);
        next_cycle();
        sample();
        chk("t4_rvalid", {31'd0, a_rvalid}, 32'd1);
        chk("t4_err", {31'd0, a_err}, 32'd1);
        next_cycle();

        // Set op on a read-only ext port (instance B) is rejected; A performs it.
        next_cycle();
        drive_ext(12'h300, 2'd2, 32'h0000_0080);
        push_a(csr_model(12'h300), 1'b0);
        push_b(32'd0, 1'b1);
        sample();
        chk("t5_b_gnt", {31'd0, b_gnt}, 32'd1);
        next_cycle();
        ext_req = 1'b0;
        sample();
        chk("t5_b_no_access", {31'd0, b_csr_access}, 32'd0);
        chk("t5_a_access", {31'd0, a_csr_access}, 32'd1);
        chk("t5_a_op", {30'd0, a_csr_op}, 32'd2);
        chk("t5_b_stall", {31'd0, b_stall}, 32'd0);
        chk("t5_b_op", {30'd0, b_csr_op}, 32'd0);
        chk("t5_b_wdata", b_csr_wdata, 32'd0);
        chk("t5_b_core_rdata", b_core_rdata, 32'hABCD_E000);
        next_cycle();
        sample();
        chk("t5_b_rvalid", {31'd0, b_rvalid}, 32'd1);
        chk("t5_b_err", {31'd0, b_err}, 32'd1);
        next_cycle();

        // Request held high: one grant every third cycle.
        for (int k = 0; k < 9; k++) begin
            next_cycle();
            drive_ext(12'h341, 2'd0, 32'd0);
            if (k % 3 == 0) begin
                push_a(32'h0000_1234, 1'b0);
                push_b(32'h0000_1234, 1'b0);
            end
            sample();
            chk("t6_gnt", {31'd0, a_gnt}, (k % 3 == 0) ? 32'd1 : 32'd0);
        end
        next_cycle();
        ext_req = 1'b0;

        // Reset while pending: request dropped, no rvalid, next request normal.
        next_cycle();
        core_access = 1'b1;
        drive_ext(12'h341, 2'd0, 32'd0);
        sample();
        chk("t7_gnt", {31'd0, a_gnt}, 32'd1);
        next_cycle();
        ext_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_gnt", {31'd0, a_gnt}, 32'd0);
        chk("t7_rst_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("t7_rst_err", {31'd0, a_err}, 32'd0);
        chk("t7_rst_rdata", a_rdata, 32'd0);
        chk("t7_rst_stall", {31'd0, a_stall}, 32'd0);
        next_cycle();
        next_cycle();
        rst_n       = 1'b1;
        core_access = 1'b0;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            sample();
            chk("t7_no_rvalid_a", {31'd0, a_rvalid}, 32'd0);
            chk("t7_no_rvalid_b", {31'd0, b_rvalid}, 32'd0);
        end
        next_cycle();
        drive_ext(12'h341, 2'd0, 32'd0);
        push_a(32'h0000_1234, 1'b0);
        push_b(32'h0000_1234, 1'b0);
        sample();
        chk("t7_regnt", {31'd0, a_gnt}, 32'd1);
        next_cycle();
        ext_req = 1'b0;
        sample();
        chk("t7_issue", {31'd0, a_csr_access}, 32'd1);
        next_cycle();
        sample();
        chk("t7_rvalid", {31'd0, a_rvalid}, 32'd1);

        next_cycle();
        next_cycle();
        chk("a_queue_empty", exp_a.size(), 32'd0);
        chk("b_queue_empty", exp_b.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flexbex_ibex_csr_arbiter.md
Name: flexbex_ibex_csr_arbiter

Overview:
- Shares the core's single CSR file port between two requesters: the ID-stage CSR instruction path (core) and an external configuration/debug port (ext).
- The core normally has priority. A starvation counter forces an ext access after MAX_WAIT cycles; in that cycle the core is stalled.
- The arbiter never lets an ext access collide with a trap save, mret or dret update of the CSR file.
- Sits between the ID stage and the CSR register file, inside the core wrapper.

Parameters:
- MAX_WAIT, 8: cycles an accepted ext request may wait before it is forced; range 1..255.
- ALLOW_EXT_WRITE, 1: 0 makes the ext port read-only; non-read ext ops then complete with an error.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- core_csr_access_i  in  1  core CSR access this cycle
- core_csr_addr_i  in  12  core CSR address
- core_csr_wdata_i  in  32  core write data
- core_csr_op_i  in  2  core op: 0 read, 1 write, 2 set, 3 clear
- core_csr_rdata_o  out  32  read data to core
- core_stall_o  out  1  core access not serviced this cycle; core retries
- ext_req_i  in  1  ext request
- ext_addr_i  in  12  ext CSR address
- ext_wdata_i  in  32  ext write data
- ext_op_i  in  2  ext op, same encoding as core_csr_op_i
- ext_gnt_o  out  1  request accepted (one-cycle pulse)
- ext_rvalid_o  out  1  response valid (one-cycle pulse)
- ext_rdata_o  out  32  ext read data (old CSR value)
- ext_err_o  out  1  error, qualified by ext_rvalid_o
- trap_busy_i  in  1  OR of csr_save_cause, csr_restore_mret and csr_restore_dret
- csr_access_o  out  1  to CSR file
- csr_addr_o  out  12  to CSR file
- csr_wdata_o  out  32  to CSR file
- csr_op_o  out  2  to CSR file
- csr_rdata_i  in  32  from CSR file (combinational read)

Behaviour:
- Reset: state IDLE, wait counter 0, latched request 0. ext_gnt_o, ext_rvalid_o, ext_err_o, ext_rdata_o and core_stall_o are all 0.
- FSM states are IDLE, PEND, RESP. Only one ext request is outstanding at a time.
- IDLE:
  - ext_gnt_o = ext_req_i (combinational).
  - On a grant, latch addr, wdata and op, then go to PEND.
  - The request is illegal if ext_op_i != 0 and either ALLOW_EXT_WRITE = 0 or ext_addr_i[11:10] = 2'b11 (read-only space). The illegal flag is latched with the request.
- PEND, illegal request: go to RESP next cycle with err = 1 and rdata = 0. Nothing is issued to the CSR file.
- PEND, legal request, issue condition: !trap_busy_i && (!core_csr_access_i || wait_cnt == MAX_WAIT).
  - Issue cycle: csr_* outputs carry the latched ext request.
  - ext_rdata_o register captures csr_rdata_i, err = 0, go to RESP.
  - If core_csr_access_i is also high, core_stall_o = 1 (combinational) and the core access is dropped.
- PEND, no issue: wait_cnt increments and saturates at MAX_WAIT.
  - trap_busy_i blocks issue even when the counter has saturated.
- RESP: ext_rvalid_o = 1 for exactly one cycle, then IDLE. wait_cnt clears to 0.
- Ext latency: grant at cycle 0, earliest issue at cycle 1, rvalid at cycle 2.
- Passthrough: in every non-issue cycle, csr_* = core_csr_*. core_stall_o = 0 outside forced-issue cycles.
- core_csr_rdata_o = csr_rdata_i at all times.
- ext_req_i is ignored while in PEND or RESP; ext_gnt_o stays 0 there.
- ext_req_i with the same or a new payload may be re-granted in the IDLE cycle directly after RESP.
- Asynchronous reset mid-operation returns the block to IDLE. The pending request is discarded and no rvalid is produced.
- Write semantics (set/clear/old-value read) are left to the CSR file. The arbiter never modifies wdata.

Decomposition:
- flexbex_ibex_pkg gains:
  - csr_op_e (CSR_READ = 0, CSR_WRITE = 1, CSR_SET = 2, CSR_CLEAR = 3)
  - the arbiter state enum (ARB_IDLE, ARB_PEND, ARB_RESP)
  - the localparam for the read-only address prefix 2'b11
- Single module; no sub-module is warranted. The wait counter is a $clog2(MAX_WAIT+1)-bit register inline.

Test Plan:
- Idle core, ext read of 0x341 while CSR file returns 0x0000_1234:
  - gnt at T0, csr_access_o with addr 0x341 and op 0 at T1.
  - rvalid at T2 with rdata 0x0000_1234, err 0.
  - core_stall_o never asserted.
- Core accesses every cycle, MAX_WAIT = 8, ext write 0x7B2 = 0xDEAD_BEEF:
  - Issue is forced exactly 9 cycles after grant, with core_stall_o = 1 in that cycle only.
  - csr_op_o = 1 and csr_wdata_o = 0xDEAD_BEEF.
  - rvalid follows one cycle later.
- trap_busy_i held high during PEND with the counter saturated: no issue and no stall. Issue occurs in the first cycle trap_busy_i = 0.
- Error cases, each giving rvalid at T2 with err = 1, rdata 0, and csr_access_o never driven by ext:
  - ext write to 0xF14 (read-only space);
  - ALLOW_EXT_WRITE = 0 with ext set (op 2) to 0x300.
- ext_req_i held high continuously: gnt pulses only in IDLE cycles, giving one transaction per 3 cycles when uncontended.
- rst_n asserted during PEND: outputs return to 0 immediately. After release, no rvalid appears and the next request is granted normally.
